// File: rtl/mipi_csi_frame_sequencer.sv
// -----------------------------------------------------------------------------
// mipi_csi_frame_sequencer
//
// Frame-level controller for the CSI-2 receive datapath, placed between the
// lane aligner and the packet decoder. It finds Frame Start / Frame End short
// packets in the lane-aligned word stream and enables the packet decoder only
// inside a frame. It follows decoder line activity to produce frame/line sync,
// frame number, line count and sticky protocol-error flags.
//
// All state changes on the FALLING edge of clk_i, which is the packet decoder's
// clock domain.
//
// Optional feature macro: MIPI_CSI_FRAME_TIMEOUT_EN
//   defined   : an idle counter aborts a frame after TIMEOUT_CYCLES consecutive
//               cycles with data_valid_i low (error_o[3], frame_end_o pulse).
//   undefined : no idle counter, error_o[3] is always 0, and a frame without FE
//               stays open indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  idle cycles tolerated inside a frame (16-bit)
//   SYNC_BYTE       byte-0 value of the word that precedes a packet header
//
// Ports
//   clk_i                  in   byte clock (falling-edge active)
//   reset_i                in   asynchronous active-high reset
//   data_valid_i           in   lane-aligned word valid
//   data_i[31:0]           in   lane-aligned word, byte 0 in [7:0]
//   decoder_output_valid_i in   packet decoder payload valid
//   packet_length_i[15:0]  in   decoder's packet length in bytes
//   err_clear_i            in   synchronous clear of error_o
//   decoder_enable_o       out  data_valid_i gated by frame_valid_o
//   frame_valid_o          out  high between accepted FS and frame close
//   line_valid_o           out  decoder_output_valid_i delayed one edge, in frame
//   frame_start_o          out  one-cycle pulse on accepted FS
//   frame_end_o            out  one-cycle pulse on FE or abort
//   frame_number_o[15:0]   out  frame number carried by the last FS
//   line_count_o[15:0]     out  completed lines in the current or last frame
//   error_o[3:0]           out  sticky: [0] FS in frame, [1] bad FE,
//                               [2] line word-count mismatch, [3] timeout
// -----------------------------------------------------------------------------
module mipi_csi_frame_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535,
    parameter logic [7:0]  SYNC_BYTE      = 8'hB8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    input  logic        decoder_output_valid_i,
    input  logic [15:0] packet_length_i,
    input  logic        err_clear_i,
    output logic        decoder_enable_o,
    output logic        frame_valid_o,
    output logic        line_valid_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic [15:0] frame_number_o,
    output logic [15:0] line_count_o,
    output logic [3:0]  error_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  prev_b0;
    logic [15:0] word_count;
    logic [15:0] line_len;

    logic        fs_det;
    logic        fe_det;
    logic        timeout_hit;
    logic        frame_open_next;
    logic [16:0] len_plus3;
    logic [15:0] expected_words;
    logic [3:0]  new_err;

    // A short packet is the word right after a sync-byte word; byte 0 of the
    // header word carries the data type (0x00 = FS, 0x01 = FE).
    assign fs_det = data_valid_i && (prev_b0 == SYNC_BYTE) && (data_i[7:0] == 8'h00);
    assign fe_det = data_valid_i && (prev_b0 == SYNC_BYTE) && (data_i[7:0] == 8'h01);

    assign decoder_enable_o = data_valid_i & frame_valid_o;

    // Words expected for a line of line_len bytes, rounded up to whole words.
    // One extra bit keeps the +3 from wrapping for lengths near 16'hFFFF.
    assign len_plus3      = {1'b0, line_len} + 17'd3;
    assign expected_words = {1'b0, len_plus3[16:2]};

`ifdef MIPI_CSI_FRAME_TIMEOUT_EN
    logic [15:0] idle_count;

    // Fires on the idle cycle that brings the count up to TIMEOUT_CYCLES.
    assign timeout_hit = (state != ST_IDLE) && !data_valid_i &&
                         (idle_count + 16'd1 == TIMEOUT_CYCLES);

    always_ff @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idle_count <= '0;
        end else if (state == ST_IDLE || data_valid_i || timeout_hit) begin
            idle_count <= '0;
        end else begin
            idle_count <= idle_count + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Frame still (or newly) open after this edge; used to gate line_valid_o.
    assign frame_open_next = fs_det ||
                             ((state != ST_IDLE) && !fe_det && !timeout_hit);

    // Error events raised by this edge. FS and FE cannot coincide (their
    // byte 0 differs), and timeout requires an idle cycle, so at most one of
    // the frame-level events is active.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        new_err = 4'b0000;
        if (fs_det && state != ST_IDLE) begin
            new_err[0] = 1'b1;
        end
        if (fe_det && state != ST_FRAME) begin
            new_err[1] = 1'b1;
        end
        if (state == ST_LINE && !fs_det && !fe_det && !timeout_hit &&
            !decoder_output_valid_i && word_count != expected_words) begin
            new_err[2] = 1'b1;
        end
        if (timeout_hit) begin
            new_err[3] = 1'b1;
        end
    end

    // Sticky error flags; a clear drops old flags but keeps this edge's events.
    always_ff @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_o <= '0;
        end else if (err_clear_i) begin
            error_o <= new_err;
        end else begin
            error_o <= error_o | new_err;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= ST_IDLE;
            prev_b0        <= '0;
            word_count     <= '0;
            line_len       <= '0;
            frame_valid_o  <= 1'b0;
            line_valid_o   <= 1'b0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            frame_number_o <= '0;
            line_count_o   <= '0;
        end else begin
            prev_b0       <= data_valid_i ? data_i[7:0] : 8'h00;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            line_valid_o  <= decoder_output_valid_i & frame_open_next;

            if (fs_det) begin
                // Accepted FS from any state: a frame already open is dropped
                // along with any partial line and restarts without frame_end_o.
                state          <= ST_FRAME;
                frame_valid_o  <= 1'b1;
                frame_start_o  <= 1'b1;
                frame_number_o <= data_i[23:8];
                line_count_o   <= '0;
                word_count     <= '0;
            end else if (state != ST_IDLE) begin
                if (fe_det || timeout_hit) begin
                    // Frame close; a line still in progress is not counted.
                    state         <= ST_IDLE;
                    frame_valid_o <= 1'b0;
                    frame_end_o   <= 1'b1;
                end else if (state == ST_LINE) begin
                    if (decoder_output_valid_i) begin
                        if (word_count != 16'hFFFF) begin
                            word_count <= word_count + 16'd1;
                        end
                    end else begin
                        state <= ST_FRAME;
                        if (line_count_o != 16'hFFFF) begin
                            line_count_o <= line_count_o + 16'd1;
                        end
                    end
                end else if (decoder_output_valid_i) begin
                    state      <= ST_LINE;
                    line_len   <= packet_length_i;
                    word_count <= 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mipi_csi_frame_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mipi_csi_frame_sequencer.
// Every cycle the outputs are compared against a behavioural model that tracks
// "frame open", "line open", words seen and lines completed directly from the
// protocol rules. Directed scenarios cover the listed behaviours; a randomized
// section mixes frames, lines, length errors, stray FS/FE and error clears.
// Build with +define+MIPI_CSI_FRAME_TIMEOUT_EN to exercise the timeout.
// -----------------------------------------------------------------------------
module tb_mipi_csi_frame_sequencer;

    localparam logic [15:0] TO   = 16'd16;
    localparam logic [7:0]  SYNC = 8'hB8;

    logic        clk_i = 1'b1;
    logic        reset_i;
    logic        data_valid_i;
    logic [31:0] data_i;
    logic        decoder_output_valid_i;
    logic [15:0] packet_length_i;
    logic        err_clear_i;
    logic        decoder_enable_o;
    logic        frame_valid_o;
    logic        line_valid_o;
    logic        frame_start_o;
    logic        frame_end_o;
    logic [15:0] frame_number_o;
    logic [15:0] line_count_o;
    logic [3:0]  error_o;

    int total = 0;
    int bad   = 0;

    mipi_csi_frame_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE     (SYNC)
    ) dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .data_valid_i          (data_valid_i),
        .data_i                (data_i),
        .decoder_output_valid_i(decoder_output_valid_i),
        .packet_length_i       (packet_length_i),
        .err_clear_i           (err_clear_i),
        .decoder_enable_o      (decoder_enable_o),
        .frame_valid_o         (frame_valid_o),
        .line_valid_o          (line_valid_o),
        .frame_start_o         (frame_start_o),
        .frame_end_o           (frame_end_o),
        .frame_number_o        (frame_number_o),
        .line_count_o          (line_count_o),
        .error_o               (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_fv;      // frame open
    bit          m_inl;     // line open
    int          m_words;   // payload cycles seen in the open line
    int          m_len;     // byte length of the open line
    int          m_lines;   // completed lines in this frame
    logic [15:0] m_fnum;
    bit          m_start;
    bit          m_end;
    bit          m_lv;
    logic [3:0]  m_err;
    logic [7:0]  m_prev;
`ifdef MIPI_CSI_FRAME_TIMEOUT_EN
    int          m_idle;
`endif

    task automatic model_reset();
        m_fv = 0; m_inl = 0; m_words = 0; m_len = 0; m_lines = 0;
        m_fnum = '0; m_start = 0; m_end = 0; m_lv = 0; m_err = '0; m_prev = '0;
`ifdef MIPI_CSI_FRAME_TIMEOUT_EN
        m_idle = 0;
`endif
    endtask

    // One falling edge worth of protocol behaviour, using the applied inputs.
    task automatic model_step();
        bit         fs;
        bit         fe;
        bit         aborted;
        logic [3:0] ne;
        fs = data_valid_i && m_prev == SYNC && data_i[7:0] == 8'h00;
        fe = data_valid_i && m_prev == SYNC && data_i[7:0] == 8'h01;
        ne = '0;
        m_start = 0;
        m_end = 0;
        aborted = 0;
        if (fs) begin
            if (m_fv) ne[0] = 1'b1;
            m_fv = 1; m_inl = 0; m_start = 1;
            m_fnum = data_i[23:8];
            m_lines = 0;
        end else if (fe) begin
            if (!m_fv || m_inl) ne[1] = 1'b1;
            if (m_fv) m_end = 1;
            m_fv = 0; m_inl = 0;
        end else if (m_fv) begin
`ifdef MIPI_CSI_FRAME_TIMEOUT_EN
            if (!data_valid_i) begin
                m_idle++;
                if (m_idle == int'(TO)) begin
                    ne[3] = 1'b1;
                    m_fv = 0; m_inl = 0; m_end = 1; aborted = 1;
                end
            end
`endif
            if (!aborted) begin
                if (m_inl) begin
                    if (decoder_output_valid_i) begin
                        if (m_words < 65535) m_words++;
                    end else begin
                        if (m_lines < 65535) m_lines++;
                        if (m_words != (m_len + 3) / 4) ne[2] = 1'b1;
                        m_inl = 0;
                    end
                end else if (decoder_output_valid_i) begin
                    m_inl = 1;
                    m_len = int'(packet_length_i);
                    m_words = 1;
                end
            end
        end
`ifdef MIPI_CSI_FRAME_TIMEOUT_EN
        if (data_valid_i || !m_fv) m_idle = 0;
`endif
        m_err  = err_clear_i ? ne : (m_err | ne);
        m_lv   = decoder_output_valid_i && m_fv;
        m_prev = data_valid_i ? data_i[7:0] : 8'h00;
    endtask

    task automatic compare_all();
        check("frame_valid",    frame_valid_o,    m_fv);
        check("line_valid",     line_valid_o,     m_lv);
        check("frame_start",    frame_start_o,    m_start);
        check("frame_end",      frame_end_o,      m_end);
        check("frame_number",   frame_number_o,   m_fnum);
        check("line_count",     line_count_o,     m_lines);
        check("error",          error_o,          m_err);
        check("decoder_enable", decoder_enable_o, data_valid_i & m_fv);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic dv, input logic [31:0] d, input logic dov,
                         input logic [15:0] len, input logic clr);
        data_valid_i           = dv;
        data_i                 = d;
        decoder_output_valid_i = dov;
        packet_length_i        = len;
        err_clear_i            = clr;
        @(negedge clk_i);
        model_step();
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] filler();
        logic [31:0] w;
        w = $urandom;
        if (w[7:0] == SYNC) w[7:0] = 8'h5A;
        return w;
    endfunction

    task automatic short_pkt(input logic [7:0] code, input logic [15:0] fnum,
                             input logic dov, input logic [15:0] len);
        logic [31:0] w;
        w = $urandom;
        cycle(1'b1, {w[31:8], SYNC}, dov, len, 1'b0);
        cycle(1'b1, {w[7:0], fnum, code}, dov, len, 1'b0);
    endtask

    task automatic send_line(input logic [15:0] len, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, filler(), 1'b1, len, 1'b0);
        cycle(1'b1, filler(), 1'b0, len, 1'b0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, filler(), 1'b0, 16'd0, 1'b0);
    endtask

    task automatic clear_errors();
        cycle(1'b1, filler(), 1'b0, 16'd0, 1'b1);
    endtask

    initial begin
        logic [15:0] fnum;
        int          nl;
        int          len;
        int          n;

        // Reset with valid data present: everything held at zero.
        reset_i = 1'b1;
        data_valid_i = 1'b1;
        data_i = {24'h000000, SYNC};
        decoder_output_valid_i = 1'b1;
        packet_length_i = 16'd40;
        err_clear_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        compare_all();
        #1 reset_i = 1'b0;
        gap(2);

        // Clean frame 5 with three 40-byte lines.
        short_pkt(8'h00, 16'h0005, 1'b0, 16'd0);
        check("fs_number", frame_number_o, 16'h0005);
        for (int l = 0; l < 3; l++) send_line(16'd40, 10);
        short_pkt(8'h01, 16'h0000, 1'b0, 16'd0);
        check("clean_lines", line_count_o, 16'd3);
        check("clean_err", error_o, 4'h0);
        gap(3);

        // Length mismatch: 38 bytes needs 10 words, 11 sent.
        short_pkt(8'h00, 16'h0007, 1'b0, 16'd0);
        send_line(16'd38, 11);
        check("mismatch_err2", error_o[2], 1'b1);
        check("mismatch_lines", line_count_o, 16'd1);
        clear_errors();
        check("cleared_err", error_o, 4'h0);
        short_pkt(8'h01, 16'h0000, 1'b0, 16'd0);

        // FS inside an open frame restarts it.
        short_pkt(8'h00, 16'h0010, 1'b0, 16'd0);
        send_line(16'd8, 2);
        short_pkt(8'h00, 16'h0011, 1'b0, 16'd0);
        check("refs_err0", error_o[0], 1'b1);
        check("refs_lines", line_count_o, 16'd0);
        check("refs_number", frame_number_o, 16'h0011);
        short_pkt(8'h01, 16'h0000, 1'b0, 16'd0);
        clear_errors();

        // FE while the decoder is still emitting a line.
        short_pkt(8'h00, 16'h0020, 1'b0, 16'd0);
        send_line(16'd12, 3);
        for (int i = 0; i < 4; i++) cycle(1'b1, filler(), 1'b1, 16'd20, 1'b0);
        short_pkt(8'h01, 16'h0000, 1'b1, 16'd20);
        check("fe_line_err1", error_o[1], 1'b1);
        check("fe_line_fv", frame_valid_o, 1'b0);
        check("fe_line_lines", line_count_o, 16'd1);
        gap(1);
        clear_errors();

        // Idle inside a frame.
        short_pkt(8'h00, 16'h0030, 1'b0, 16'd0);
        gap(16);
`ifdef MIPI_CSI_FRAME_TIMEOUT_EN
        check("timeout_err3", error_o[3], 1'b1);
        check("timeout_fv", frame_valid_o, 1'b0);
`else
        check("no_timeout_fv", frame_valid_o, 1'b1);
        check("no_timeout_err", error_o, 4'h0);
        short_pkt(8'h01, 16'h0000, 1'b0, 16'd0);
`endif
        gap(2);
        clear_errors();

        // Reset in the middle of a line.
        short_pkt(8'h00, 16'h0040, 1'b0, 16'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, filler(), 1'b1, 16'd16, 1'b0);
        reset_i = 1'b1;
        model_reset();
        #1;
        check("rst_mid_enable", decoder_enable_o, 1'b0);
        check("rst_mid_fv", frame_valid_o, 1'b0);
        check("rst_mid_lv", line_valid_o, 1'b0);
        check("rst_mid_fnum", frame_number_o, 16'h0000);
        check("rst_mid_end", frame_end_o, 1'b0);
        compare_all();
        #1 reset_i = 1'b0;
        gap(2);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) short_pkt(8'h01, 16'h0000, 1'b0, 16'd0);
            fnum = 16'($urandom);
            short_pkt(8'h00, fnum, 1'b0, 16'd0);
            nl = $urandom_range(0, 4);
            for (int l = 0; l < nl; l++) begin
                len = $urandom_range(1, 80);
                n = (len + 3) / 4;
                if ($urandom_range(0, 3) == 0) n = n + 1;
                else if ($urandom_range(0, 3) == 0 && n > 1) n = n - 1;
                send_line(16'(len), n);
                gap($urandom_range(0, 2));
                if ($urandom_range(0, 7) == 0) clear_errors();
            end
            case ($urandom_range(0, 9))
                0: begin
                    short_pkt(8'h00, 16'($urandom), 1'b0, 16'd0);
                    short_pkt(8'h01, 16'h0000, 1'b0, 16'd0);
                end
                1: begin
                    for (int i = 0; i < 2; i++) cycle(1'b1, filler(), 1'b1, 16'd9, 1'b0);
                    short_pkt(8'h01, 16'h0000, 1'b1, 16'd9);
                end
                default: short_pkt(8'h01, 16'h0000, 1'b0, 16'd0);
            endcase
            gap($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
